keymatrix_ctrl: RTL and testbench

Sequencer and arbiter for the 8×8 keyboard row RAM's CPU-side port (A/WR/DI/DO). It turns key make/break events into atomic read-modify-write cycles on one row byte, and shares the port with a host bus (plain reads and writes). It also provides a sweep that releases all keys. It sits between the scancode decoder, the host bus and the row RAM; the matrix-scan side of the RAM is untouched.

---
 rtl/keymatrix_pkg.sv | 21 ++
 rtl/keymatrix_rr_arb.sv | 32 +++
 rtl/keymatrix_ctrl.sv | 159 +++++++++++++++
 tb/tb_keymatrix_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keymatrix_pkg.sv
// Shared types and constants for the keyboard row-RAM controller.
package keymatrix_pkg;
   localparam int ROW_W = 3;
   localparam int COL_W = 3;
   localparam int DAT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      EV_RD,
      EV_MOD,
      EV_WR,
      H_RD,
      H_DONE,
      CLR_RUN
   } km_state_e;

   // Byte stored for a row in which every key is released.
   function automatic logic [DAT_W-1:0] released_byte(input logic pressed_level);
      return {DAT_W{~pressed_level}};
   endfunction
endpackage

// File: rtl/keymatrix_rr_arb.sv
// Two-requester round-robin arbiter (event vs host); the last-grant register moves only when adv_i
// takes a grant. Combinational grant, no added latency.
module keymatrix_rr_arb (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic ev_req_i,
   input  logic host_req_i,
   input  logic adv_i,
   output logic ev_gnt_o,
   output logic host_gnt_o
);
   logic last_ev_q;
   logic last_ev_d;

   always_comb begin
      ev_gnt_o   = ev_req_i & (~host_req_i | ~last_ev_q);
      host_gnt_o = host_req_i & (~ev_req_i | last_ev_q);
      last_ev_d  = last_ev_q;
      if (adv_i && (ev_gnt_o || host_gnt_o)) begin
         last_ev_d = ev_gnt_o;
      end
   end

   // Resets to "host granted last", so the event wins the first tie.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_ev_q <= 1'b0;
      end else begin
         last_ev_q <= last_ev_d;
      end
   end
endmodule

// File: rtl/keymatrix_ctrl.sv
// Row-RAM port sequencer: atomic key make/break RMWs, host reads/writes and a release-all sweep.
// Event 4 cycles (3 on duplicate), host write ack +1, read ack +2; backpressure via EV_READY / held HOST_REQ.
module keymatrix_ctrl
   import keymatrix_pkg::*;
#(
   parameter logic PRESSED_LEVEL = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             ev_valid_i,
   output logic             ev_ready_o,
   input  logic [ROW_W-1:0] ev_row_i,
   input  logic [COL_W-1:0] ev_col_i,
   input  logic             ev_press_i,
   output logic             dup_ev_o,
   input  logic             host_req_i,
   input  logic             host_wr_i,
   input  logic [ROW_W-1:0] host_a_i,
   input  logic [DAT_W-1:0] host_di_i,
   output logic [DAT_W-1:0] host_do_o,
   output logic             host_ack_o,
   input  logic             clr_i,
   output logic             clr_busy_o,
   output logic [ROW_W-1:0] ram_a_o,
   output logic             ram_wr_o,
   output logic [DAT_W-1:0] ram_di_o,
   input  logic [DAT_W-1:0] ram_do_i
);
   km_state_e        state_q;
   logic [ROW_W-1:0] ram_a_q;
   logic             ram_wr_q;
   logic [DAT_W-1:0] ram_di_q;
   logic [DAT_W-1:0] host_do_q;
   logic             host_ack_q;
   logic             dup_ev_q;
   logic             clr_pend_q;
   logic [ROW_W-1:0] cnt_q;
   logic [COL_W-1:0] col_q;
   logic             press_q;
   logic             h_wr_q;

   logic             grant_en;
   logic             host_pend;
   logic             ev_gnt;
   logic             host_gnt;
   logic [DAT_W-1:0] new_byte;

   // The ack cycle overlaps IDLE; masking keeps a still-high HOST_REQ from being granted twice.
   assign host_pend = host_req_i & ~host_ack_q;
   assign grant_en  = (state_q == IDLE) & ~clr_pend_q;

   keymatrix_rr_arb u_arb (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .ev_req_i  (ev_valid_i),
      .host_req_i(host_pend),
      .adv_i     (grant_en),
      .ev_gnt_o  (ev_gnt),
      .host_gnt_o(host_gnt)
   );

   always_comb begin
      new_byte        = ram_do_i;
      new_byte[col_q] = press_q ? PRESSED_LEVEL : ~PRESSED_LEVEL;
   end

   assign ev_ready_o = grant_en & ev_gnt & rst_n_i;
   assign dup_ev_o   = dup_ev_q;
   assign host_do_o  = host_do_q;
   assign host_ack_o = host_ack_q;
   assign clr_busy_o = clr_pend_q;
   assign ram_a_o    = ram_a_q;
   assign ram_wr_o   = ram_wr_q;
   assign ram_di_o   = ram_di_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         ram_a_q    <= '0;
         ram_wr_q   <= 1'b0;
         ram_di_q   <= '0;
         host_do_q  <= '0;
         host_ack_q <= 1'b0;
         dup_ev_q   <= 1'b0;
         clr_pend_q <= 1'b0;
         cnt_q      <= '0;
         col_q      <= '0;
         press_q    <= 1'b0;
         h_wr_q     <= 1'b0;
      end else begin
         dup_ev_q   <= 1'b0;
         host_ack_q <= 1'b0;
         if (clr_i && state_q != CLR_RUN) begin
            clr_pend_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (clr_pend_q) begin
                  state_q  <= CLR_RUN;
                  cnt_q    <= '0;
                  ram_a_q  <= '0;
                  ram_di_q <= released_byte(PRESSED_LEVEL);
                  ram_wr_q <= 1'b1;
               end else if (ev_gnt) begin
                  state_q <= EV_RD;
                  ram_a_q <= ev_row_i;
                  col_q   <= ev_col_i;
                  press_q <= ev_press_i;
               end else if (host_gnt) begin
                  ram_a_q <= host_a_i;
                  h_wr_q  <= host_wr_i;
                  if (host_wr_i) begin
                     ram_di_q <= host_di_i;
                     ram_wr_q <= 1'b1;
                     state_q  <= H_DONE;
                  end else begin
                     state_q <= H_RD;
                  end
               end
            end
            EV_RD: state_q <= EV_MOD;
            EV_MOD: begin
               if (new_byte == ram_do_i) begin
                  dup_ev_q <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  ram_di_q <= new_byte;
                  ram_wr_q <= 1'b1;
                  state_q  <= EV_WR;
               end
            end
            EV_WR: begin
               ram_wr_q <= 1'b0;
               state_q  <= IDLE;
            end
            H_RD: state_q <= H_DONE;
            // Read data arrives one cycle after the RAM samples the address, i.e. here.
            H_DONE: begin
               ram_wr_q   <= 1'b0;
               host_ack_q <= 1'b1;
               if (!h_wr_q) begin
                  host_do_q <= ram_do_i;
               end
               state_q <= IDLE;
            end
            CLR_RUN: begin
               cnt_q   <= cnt_q + 3'd1;
               ram_a_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  ram_wr_q   <= 1'b0;
                  clr_pend_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_keymatrix_ctrl.sv
// Bench for keymatrix_ctrl: bench-side row RAM, vector table, corner sequences, randomized model check.
module tb_keymatrix_ctrl;
   localparam logic PL = 1'b1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ev_valid, ev_ready, ev_press, dup_ev;
   logic [2:0] ev_row, ev_col;
   logic       host_req, host_wr, host_ack;
   logic [2:0] host_a;
   logic [7:0] host_di, host_do;
   logic       clr, clr_busy;
   logic [2:0] ram_a;
   logic       ram_wr;
   logic [7:0] ram_di;
   logic [7:0] ram_do = 8'h00;
   logic [7:0] mem [8] = '{default: 8'h00};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   keymatrix_ctrl #(.PRESSED_LEVEL(PL)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .ev_valid_i(ev_valid), .ev_ready_o(ev_ready), .ev_row_i(ev_row), .ev_col_i(ev_col),
      .ev_press_i(ev_press), .dup_ev_o(dup_ev),
      .host_req_i(host_req), .host_wr_i(host_wr), .host_a_i(host_a), .host_di_i(host_di),
      .host_do_o(host_do), .host_ack_o(host_ack),
      .clr_i(clr), .clr_busy_o(clr_busy),
      .ram_a_o(ram_a), .ram_wr_o(ram_wr), .ram_di_o(ram_di), .ram_do_i(ram_do)
   );

   // Row RAM with registered read port.
   always @(posedge clk) begin
      if (ram_wr) mem[ram_a] <= ram_di;
      ram_do <= mem[ram_a];
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic wait_ready(input string name);
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if (ev_ready) break;
      end
      check(name, 32'(ev_ready), 32'd1);
   endtask

   // Offer one event, then watch six cycles after the accepting edge (index 0 = first cycle after it).
   task automatic ev_txn(input logic [2:0] row, input logic [2:0] col, input logic pr,
                         output int nwr, output int widx, output logic [7:0] wdi,
                         output logic [2:0] wa, output int ndup);
      nwr = 0; widx = -1; wdi = 8'h00; wa = 3'd0; ndup = 0;
      @(posedge clk); #1;
      ev_row = row; ev_col = col; ev_press = pr; ev_valid = 1'b1;
      wait_ready("ev_accept");
      if (!ev_ready) begin
         ev_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      ev_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ram_wr) begin nwr++; widx = i; wdi = ram_di; wa = ram_a; end
         if (dup_ev) ndup++;
      end
   endtask

   task automatic host_txn(input logic wr, input logic [2:0] a, input logic [7:0] di,
                           output int ack_idx, output logic [7:0] dout, output int nwr);
      ack_idx = -1; dout = 8'h00; nwr = 0;
      @(posedge clk); #1;
      host_wr = wr; host_a = a; host_di = di; host_req = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ram_wr) nwr++;
         if (host_ack && ack_idx < 0) begin
            ack_idx = i; dout = host_do; host_req = 1'b0;
         end
      end
      host_req = 1'b0;
   endtask

   typedef struct {
      logic [2:0] row;
      logic [2:0] col;
      logic       press;
      logic       exp_wr;
      logic [7:0] exp_di;
      logic       exp_dup;
   } vec_t;

   vec_t       vt [8];
   int         nwr, widx, ndup, ack_idx, g, n, nw;
   logic [7:0] wdi, dout, nb;
   logic [2:0] wa, ra, rc;
   logic       rp;
   int         order [3];
   logic [2:0] sa [20];
   logic [7:0] sd [20];
   int         sc [20];
   bit         sent2;
   logic [7:0] ref_mem [8];
   int         op;

   initial begin
      vt[0] = '{3'd3, 3'd5, 1'b1, 1'b1, 8'h20, 1'b0};
      vt[1] = '{3'd3, 3'd5, 1'b1, 1'b0, 8'h00, 1'b1};
      vt[2] = '{3'd3, 3'd5, 1'b0, 1'b1, 8'h00, 1'b0};
      vt[3] = '{3'd3, 3'd0, 1'b1, 1'b1, 8'h01, 1'b0};
      vt[4] = '{3'd3, 3'd7, 1'b1, 1'b1, 8'h81, 1'b0};
      vt[5] = '{3'd0, 3'd2, 1'b0, 1'b0, 8'h00, 1'b1};
      vt[6] = '{3'd7, 3'd7, 1'b1, 1'b1, 8'h80, 1'b0};
      vt[7] = '{3'd3, 3'd0, 1'b0, 1'b1, 8'h80, 1'b0};

      rst_n = 1'b0; clr = 1'b0;
      ev_valid = 1'b1; ev_row = 3'd1; ev_col = 3'd1; ev_press = 1'b1;
      host_req = 1'b0; host_wr = 1'b0; host_a = 3'd0; host_di = 8'h00;

      // Reset values, then EV_READY in the first cycle after release.
      repeat (3) @(negedge clk);
      check("rst_ev_ready", 32'(ev_ready), 32'd0);
      check("rst_ram_a", 32'(ram_a), 32'd0);
      check("rst_ram_wr", 32'(ram_wr), 32'd0);
      check("rst_ram_di", 32'(ram_di), 32'd0);
      check("rst_host_do", 32'(host_do), 32'd0);
      check("rst_host_ack", 32'(host_ack), 32'd0);
      check("rst_dup_ev", 32'(dup_ev), 32'd0);
      check("rst_clr_busy", 32'(clr_busy), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(ev_ready), 32'd1);
      ev_valid = 1'b0;

      // Event vector table.
      foreach (vt[i]) begin
         ev_txn(vt[i].row, vt[i].col, vt[i].press, nwr, widx, wdi, wa, ndup);
         check("vec_nwr", 32'(nwr), 32'(vt[i].exp_wr));
         check("vec_dup", 32'(ndup), 32'(vt[i].exp_dup));
         if (vt[i].exp_wr) begin
            check("vec_wr_idx", 32'(widx), 32'd2);
            check("vec_ram_a", 32'(wa), 32'(vt[i].row));
            check("vec_ram_di", 32'(wdi), 32'(vt[i].exp_di));
         end
      end

      // EV_READY gap with EV_VALID held: 3 cycles on a write, 2 on a duplicate.
      @(posedge clk); #1;
      ev_row = 3'd2; ev_col = 3'd4; ev_press = 1'b1; ev_valid = 1'b1;
      wait_ready("gap_accept");
      @(posedge clk);
      g = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (ev_ready) break; g++; end
      check("gap_write", 32'(g), 32'd3);
      @(posedge clk);
      g = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (ev_ready) break; g++; end
      check("gap_dup", 32'(g), 32'd2);
      check("gap_dup_pulse", 32'(dup_ev), 32'd1);
      ev_valid = 1'b0;

      // Host write then read back.
      host_txn(1'b1, 3'd6, 8'hA5, ack_idx, dout, nwr);
      check("hwr_ack_idx", 32'(ack_idx), 32'd1);
      check("hwr_nwr", 32'(nwr), 32'd1);
      check("hwr_mem", 32'(mem[6]), 32'hA5);
      host_txn(1'b0, 3'd6, 8'h00, ack_idx, dout, nwr);
      check("hrd_ack_idx", 32'(ack_idx), 32'd2);
      check("hrd_data", 32'(dout), 32'hA5);
      check("hrd_nwr", 32'(nwr), 32'd0);

      // Tie between host and event: grants alternate E, H, E.
      @(posedge clk); #1;
      host_req = 1'b1; host_wr = 1'b0; host_a = 3'd3;
      ev_row = 3'd5; ev_col = 3'd1; ev_press = 1'b1; ev_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 3; c++) begin
         @(negedge clk);
         if (host_ack) begin order[n] = 2; n++; host_req = 1'b0; end
         if (n < 3 && ev_valid && ev_ready) begin order[n] = 1; n++; end
      end
      @(posedge clk); #1 ev_valid = 1'b0; host_req = 1'b0;
      repeat (6) @(negedge clk);
      check("tie_0_event", 32'(order[0]), 32'd1);
      check("tie_1_host", 32'(order[1]), 32'd2);
      check("tie_2_event", 32'(order[2]), 32'd1);

      // CLR while an event RMW is in flight, with a second CLR mid-sweep.
      @(posedge clk); #1;
      ev_row = 3'd4; ev_col = 3'd3; ev_press = 1'b1; ev_valid = 1'b1;
      wait_ready("clr_ev_accept");
      @(posedge clk); #1 ev_valid = 1'b0; clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      nw = 0; sent2 = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         clr = 1'b0;
         if (ram_wr && nw < 20) begin sa[nw] = ram_a; sd[nw] = ram_di; sc[nw] = c; nw++; end
         if (!sent2 && nw == 4) begin clr = 1'b1; sent2 = 1'b1; end
      end
      check("clr_total_writes", 32'(nw), 32'd9);
      check("clr_ev_row", 32'(sa[0]), 32'd4);
      check("clr_ev_data", 32'(sd[0]), 32'h08);
      for (int i = 1; i < 9; i++) begin
         check("sweep_row", 32'(sa[i]), 32'(i - 1));
         check("sweep_data", 32'(sd[i]), 32'h00);
         check("sweep_consecutive", 32'(sc[i]), 32'(sc[1] + i - 1));
      end
      check("clr_busy_done", 32'(clr_busy), 32'd0);
      foreach (mem[r]) check("clr_mem", 32'(mem[r]), 32'h00);

      // Randomized traffic against a row-image model.
      foreach (ref_mem[r]) ref_mem[r] = 8'h00;
      for (int k = 0; k < 40; k++) begin
         op = int'($urandom_range(0, 3));
         ra = 3'($urandom_range(0, 7));
         rc = 3'($urandom_range(0, 7));
         rp = 1'($urandom_range(0, 1));
         if (op <= 1) begin
            nb = ref_mem[ra];
            nb[rc] = rp ? PL : ~PL;
            ev_txn(ra, rc, rp, nwr, widx, wdi, wa, ndup);
            check("rnd_dup", 32'(ndup), (nb == ref_mem[ra]) ? 32'd1 : 32'd0);
            check("rnd_nwr", 32'(nwr), (nb == ref_mem[ra]) ? 32'd0 : 32'd1);
            if (nb != ref_mem[ra]) check("rnd_di", 32'(wdi), 32'(nb));
            ref_mem[ra] = nb;
         end else if (op == 2) begin
            nb = 8'($urandom);
            host_txn(1'b1, ra, nb, ack_idx, dout, nwr);
            check("rnd_hwr_ack", 32'(ack_idx), 32'd1);
            ref_mem[ra] = nb;
         end else begin
            host_txn(1'b0, ra, 8'h00, ack_idx, dout, nwr);
            check("rnd_hrd_ack", 32'(ack_idx), 32'd2);
            check("rnd_hrd_data", 32'(dout), 32'(ref_mem[ra]));
         end
      end
      foreach (ref_mem[r]) check("rnd_mem", 32'(mem[r]), 32'(ref_mem[r]));

      // Idle CLR timing, then reset mid-sweep drops RAM_WR at once.
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      @(negedge clk);
      check("clr_busy_set", 32'(clr_busy), 32'd1);
      check("clr_no_wr_yet", 32'(ram_wr), 32'd0);
      @(negedge clk);
      check("sweep_start_wr", 32'(ram_wr), 32'd1);
      check("sweep_start_a", 32'(ram_a), 32'd0);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("rst_mid_sweep_wr", 32'(ram_wr), 32'd0);
      check("rst_mid_sweep_busy", 32'(clr_busy), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the end, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
